// File: rtl/booth_mult_param.sv
// rtl/booth_mult_param.sv - parametrised sequential Booth multiplier (radix-2 / radix-4, signed or unsigned)
// Operands are extended by two bits so one Booth datapath serves both signed and unsigned modes.
module booth_mult_param #(
   parameter int WIDTH  = 16,
   parameter int RADIX4 = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 op_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 ready,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int WI    = WIDTH + 2;
   localparam int AW    = WI + 1;
   localparam int NSTEP = (RADIX4 != 0) ? WI / 2 : WI;
   localparam int CW    = $clog2(NSTEP + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [WI-1:0]        r_m;
   logic [WI-1:0]        r_q;
   logic [AW-1:0]        r_a;
   logic                 r_q1;
   logic [CW-1:0]        r_count;
   logic [2*WIDTH-1:0]   r_product;

   logic                 w_accept;
   logic                 w_last;
   logic [2:0]           w_digit;
   logic [AW-1:0]        w_m1;
   logic [AW-1:0]        w_addend;
   logic [AW-1:0]        w_sum;
   logic [AW-1:0]        w_a_nxt;
   logic [WI-1:0]        w_q_nxt;
   logic                 w_q1_nxt;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = (r_count == CW'(1));
   assign w_digit  = {r_q[1], r_q[0], r_q1};
   assign w_m1     = {r_m[WI-1], r_m};
   assign w_sum    = r_a + w_addend;

   always_comb begin
      w_addend = '0;
      if (RADIX4 != 0) begin
         case (w_digit)
            3'b001, 3'b010: w_addend = w_m1;
            3'b011:         w_addend = {r_m, 1'b0};
            3'b100:         w_addend = -{r_m, 1'b0};
            3'b101, 3'b110: w_addend = -w_m1;
            default:        w_addend = '0;
         endcase
      end else begin
         case (w_digit[1:0])
            2'b01:   w_addend = w_m1;
            2'b10:   w_addend = -w_m1;
            default: w_addend = '0;
         endcase
      end
   end

   // Arithmetic right shift of the combined {A,Q,Q-1} register after the add.
   always_comb begin
      if (RADIX4 != 0) begin
         w_a_nxt  = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
         w_q_nxt  = {w_sum[1:0], r_q[WI-1:2]};
         w_q1_nxt = r_q[1];
      end else begin
         w_a_nxt  = {w_sum[AW-1], w_sum[AW-1:1]};
         w_q_nxt  = {w_sum[0], r_q[WI-1:1]};
         w_q1_nxt = r_q[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_CALC;
         S_CALC:  if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      ready = (r_state == S_IDLE);
      done  = (r_state == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m       <= '0;
         r_q       <= '0;
         r_a       <= '0;
         r_q1      <= 1'b0;
         r_count   <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_m     <= op_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
         r_q     <= op_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
         r_a     <= '0;
         r_q1    <= 1'b0;
         r_count <= CW'(NSTEP);
      end else if (r_state == S_CALC) begin
         r_a     <= w_a_nxt;
         r_q     <= w_q_nxt;
         r_q1    <= w_q1_nxt;
         r_count <= r_count - CW'(1);
         if (w_last) begin
            r_product <= {w_a_nxt[WIDTH-3:0], w_q_nxt};
         end
      end
   end

   assign product = r_product;

endmodule
